// File: rtl/bus_mailbox.sv
// -----------------------------------------------------------------------------
// bus_mailbox
//
// Bidirectional byte mailbox between a local CPU (simple strobe bus) and a
// host (Wishbone classic slave). Two 8-entry byte FIFOs:
//   H2C : host pushes, CPU pops
//   C2H : CPU pushes, host pops
//
// CPU register map (addr):
//   0 DATA   read pops H2C head, write pushes C2H
//   1 STATUS {2'b0, underflow, overflow, c2h_full, c2h_empty, h2c_full, h2c_nempty}
//   2 CTRL   bit0 rx_ie, bit1 err_ie; write bit7=1 clears both sticky bits
//   3 COUNT  {h2c_count[3:0], c2h_count[3:0]}
//
// Host register map (wbs_adr_i[3:2]):
//   0 DATA   read pops C2H head, write pushes H2C
//   1 STATUS same bits as CPU STATUS
//   2 COUNT  same as CPU COUNT
//   3 reads 0x00, writes ignored
//
// Ports:
//   wb_clk_i         clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   addr, data_in    CPU register address / write data
//   data_out         CPU read data (combinational)
//   bus_cyc, bus_we  CPU one-cycle access strobe and write qualifier
//   sel              mailbox chip-select
//   wbs_*            host Wishbone slave port (wbs_dat_o registered)
//   irq, host_irq    CPU / host level interrupts
//
// Build option: BUS_MAILBOX_IRQ_EN
//   defined   -> CTRL bits 1:0 implemented, irq/host_irq registered from state
//   undefined -> irq and host_irq tied low, CTRL reads 0x00
// -----------------------------------------------------------------------------
module bus_mailbox (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       bus_cyc,
  input  logic       bus_we,
  input  logic       sel,
  input  logic       wbs_cyc_i,
  input  logic       wbs_stb_i,
  input  logic       wbs_we_i,
  input  logic [3:0] wbs_adr_i,
  input  logic [7:0] wbs_dat_i,
  output logic [7:0] wbs_dat_o,
  output logic       wbs_ack_o,
  output logic       irq,
  output logic       host_irq
);

  localparam int         DEPTH       = 8;
  localparam logic [3:0] CNT_FULL    = 4'(DEPTH);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  localparam logic [1:0] HREG_DATA   = 2'd0;
  localparam logic [1:0] HREG_STATUS = 2'd1;
  localparam logic [1:0] HREG_COUNT  = 2'd2;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic       cpu_acc, cpu_wr, cpu_rd;
  logic       host_acc, host_wr, host_rd;
  logic [1:0] host_reg;

  assign cpu_acc  = sel & bus_cyc;
  assign cpu_wr   = cpu_acc & bus_we;
  assign cpu_rd   = cpu_acc & ~bus_we;

  // The pending ack blocks re-acceptance, so a held strobe is one access.
  assign host_acc = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign host_wr  = host_acc & wbs_we_i;
  assign host_rd  = host_acc & ~wbs_we_i;
  assign host_reg = wbs_adr_i[3:2];

  logic h2c_push, h2c_pop, c2h_push, c2h_pop, sticky_clr;

  assign h2c_push   = host_wr & (host_reg == HREG_DATA);
  assign h2c_pop    = cpu_rd  & (addr == REG_DATA);
  assign c2h_push   = cpu_wr  & (addr == REG_DATA);
  assign c2h_pop    = host_rd & (host_reg == HREG_DATA);
  assign sticky_clr = cpu_wr  & (addr == REG_CTRL) & data_in[7];

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0] h2c_mem [DEPTH];
  logic [7:0] c2h_mem [DEPTH];
  logic [2:0] h2c_wr_ptr, h2c_rd_ptr, c2h_wr_ptr, c2h_rd_ptr;
  logic [3:0] h2c_cnt, c2h_cnt;

  logic h2c_empty, h2c_full, c2h_empty, c2h_full;
  logic h2c_push_ok, h2c_pop_ok, c2h_push_ok, c2h_pop_ok;
  logic ovf_evt, unf_evt;

  assign h2c_empty = (h2c_cnt == 4'd0);
  assign h2c_full  = (h2c_cnt == CNT_FULL);
  assign c2h_empty = (c2h_cnt == 4'd0);
  assign c2h_full  = (c2h_cnt == CNT_FULL);

  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  // A pop of an empty FIFO fails even if a push lands on the same edge.
  assign h2c_pop_ok  = h2c_pop & ~h2c_empty;
  assign h2c_push_ok = h2c_push & (~h2c_full | h2c_pop_ok);
  assign c2h_pop_ok  = c2h_pop & ~c2h_empty;
  assign c2h_push_ok = c2h_push & (~c2h_full | c2h_pop_ok);

  assign ovf_evt = (h2c_push & ~h2c_push_ok) | (c2h_push & ~c2h_push_ok);
  assign unf_evt = (h2c_pop & h2c_empty) | (c2h_pop & c2h_empty);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      h2c_wr_ptr <= 3'd0;
      h2c_rd_ptr <= 3'd0;
      h2c_cnt    <= 4'd0;
      c2h_wr_ptr <= 3'd0;
      c2h_rd_ptr <= 3'd0;
      c2h_cnt    <= 4'd0;
    end else begin
      if (h2c_push_ok) h2c_wr_ptr <= h2c_wr_ptr + 3'd1;
      if (h2c_pop_ok)  h2c_rd_ptr <= h2c_rd_ptr + 3'd1;
      h2c_cnt <= h2c_cnt + 4'(h2c_push_ok) - 4'(h2c_pop_ok);
      if (c2h_push_ok) c2h_wr_ptr <= c2h_wr_ptr + 3'd1;
      if (c2h_pop_ok)  c2h_rd_ptr <= c2h_rd_ptr + 3'd1;
      c2h_cnt <= c2h_cnt + 4'(c2h_push_ok) - 4'(c2h_pop_ok);
    end
  end

  // Storage is not reset; the counts alone define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (h2c_push_ok) h2c_mem[h2c_wr_ptr] <= wbs_dat_i;
    if (c2h_push_ok) c2h_mem[c2h_wr_ptr] <= data_in;
  end

  // ---------------------------------------------------------------------------
  // Sticky error bits: a same-edge error event beats the clear
  // ---------------------------------------------------------------------------
  logic ovf_sticky, unf_sticky;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_evt | (ovf_sticky & ~sticky_clr);
      unf_sticky <= unf_evt | (unf_sticky & ~sticky_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Control register and interrupts
  // ---------------------------------------------------------------------------
  logic [7:0] ctrl_rd;

`ifdef BUS_MAILBOX_IRQ_EN
  logic rx_ie, err_ie;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_ie    <= 1'b0;
      err_ie   <= 1'b0;
      irq      <= 1'b0;
      host_irq <= 1'b0;
    end else begin
      if (cpu_wr && (addr == REG_CTRL)) begin
        rx_ie  <= data_in[0];
        err_ie <= data_in[1];
      end
      irq      <= (rx_ie & ~h2c_empty) | (err_ie & (ovf_sticky | unf_sticky));
      host_irq <= ~c2h_empty;
    end
  end

  assign ctrl_rd = {6'b0, err_ie, rx_ie};

  logic unused_ok;
  assign unused_ok = ^{data_in[6:2], wbs_adr_i[1:0]};
`else
  assign irq      = 1'b0;
  assign host_irq = 1'b0;
  assign ctrl_rd  = 8'h00;

  logic unused_ok;
  assign unused_ok = ^{data_in[6:0], wbs_adr_i[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Read muxes
  // ---------------------------------------------------------------------------
  logic [7:0] status_rd, count_rd, h2c_head, c2h_head, host_rd_val;

  assign status_rd = {2'b00, unf_sticky, ovf_sticky,
                      c2h_full, c2h_empty, h2c_full, ~h2c_empty};
  assign count_rd  = {h2c_cnt, c2h_cnt};

  // An empty FIFO reads as 0x00 rather than stale storage.
  assign h2c_head  = h2c_empty ? 8'h00 : h2c_mem[h2c_rd_ptr];
  assign c2h_head  = c2h_empty ? 8'h00 : c2h_mem[c2h_rd_ptr];

  always_comb begin
    data_out = 8'h00;
    case (addr)
      REG_DATA:   data_out = h2c_head;
      REG_STATUS: data_out = status_rd;
      REG_CTRL:   data_out = ctrl_rd;
      REG_COUNT:  data_out = count_rd;
      default:    data_out = 8'h00;
    endcase
  end

  always_comb begin
    host_rd_val = 8'h00;
    case (host_reg)
      HREG_DATA:   host_rd_val = c2h_head;
      HREG_STATUS: host_rd_val = status_rd;
      HREG_COUNT:  host_rd_val = count_rd;
      default:     host_rd_val = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Host response: data captured at accept, ack in the following cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 8'h00;
    end else begin
      wbs_ack_o <= host_acc;
      if (host_acc) wbs_dat_o <= host_rd_val;
    end
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// -----------------------------------------------------------------------------
// tb_bus_mailbox
//
// Directed bench for bus_mailbox. Inputs change on the falling edge, outputs
// are sampled on the falling edge (or just after it), away from the rising
// active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bus_mailbox;

  logic       wb_clk_i = 1'b0;
  logic       rst_n;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       bus_cyc, bus_we, sel;
  logic       wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0] wbs_adr_i;
  logic [7:0] wbs_dat_i;
  logic [7:0] wbs_dat_o;
  logic       wbs_ack_o;
  logic       irq, host_irq;

  int n_checks = 0;
  int n_fail   = 0;

  bus_mailbox dut (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .bus_cyc   (bus_cyc),
    .bus_we    (bus_we),
    .sel       (sel),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .irq       (irq),
    .host_irq  (host_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Combinational look at a CPU register without an access strobe.
  task automatic peek(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    #1 v = data_out;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge wb_clk_i);
    sel = 1'b1; bus_cyc = 1'b1; bus_we = 1'b1; addr = a; data_in = d;
    @(negedge wb_clk_i);
    sel = 1'b0; bus_cyc = 1'b0; bus_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge wb_clk_i);
    sel = 1'b1; bus_cyc = 1'b1; bus_we = 1'b0; addr = a;
    #1 v = data_out;
    @(negedge wb_clk_i);
    sel = 1'b0; bus_cyc = 1'b0;
  endtask

  // One host access; returns read data and the number of cycles to ack.
  task automatic host_xfer(input logic we, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] v, output int lat);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {a, 2'b00}; wbs_dat_i = d;
    lat = 0;
    do begin
      @(negedge wb_clk_i);
      lat++;
    end while (!wbs_ack_o && lat < 4);
    if (!wbs_ack_o) check("host_ack_timeout", 16'(wbs_ack_o), 16'd1);
    v = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  logic [7:0] v;
  int         lat;
  logic [7:0] exp_c2h [8];

  initial begin
    rst_n = 1'b0;
    addr = 2'd0; data_in = 8'h00; bus_cyc = 1'b0; bus_we = 1'b0; sel = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = 4'd0; wbs_dat_i = 8'h00;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check("rst_ack", 16'(wbs_ack_o), 16'd0);
    check("rst_wbs_dat", 16'(wbs_dat_o), 16'h00);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_host_irq", 16'(host_irq), 16'd0);
    peek(2'd1, v); check("rst_status", 16'(v), 16'h04);
    peek(2'd3, v); check("rst_count", 16'(v), 16'h00);
    peek(2'd2, v); check("rst_ctrl", 16'(v), 16'h00);
    peek(2'd0, v); check("rst_data_empty", 16'(v), 16'h00);
    @(negedge wb_clk_i);
    rst_n = 1'b1;

    // H2C fill, overflow, ordered drain
    for (int i = 0; i < 8; i++) host_xfer(1'b1, 2'd0, 8'(8'h11 + i), v, lat);
    peek(2'd3, v); check("h2c_full_count", 16'(v), 16'h80);
    peek(2'd1, v); check("h2c_full_status", 16'(v), 16'h07);
    host_xfer(1'b1, 2'd0, 8'h99, v, lat);
    peek(2'd1, v); check("h2c_ovf_status", 16'(v), 16'h17);
    peek(2'd3, v); check("h2c_ovf_count", 16'(v), 16'h80);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(2'd0, v);
      check($sformatf("h2c_drain_%0d", i), 16'(v), 16'(8'h11 + i));
    end
    peek(2'd3, v); check("h2c_drained_count", 16'(v), 16'h00);
    cpu_wr(2'd2, 8'h80);
    peek(2'd1, v); check("ovf_cleared", 16'(v), 16'h04);

    // Host pops empty C2H
    host_xfer(1'b0, 2'd0, 8'h00, v, lat);
    check("c2h_empty_rd", 16'(v), 16'h00);
    check("c2h_empty_lat", 16'(lat), 16'd1);
    peek(2'd1, v); check("unf_status", 16'(v), 16'h24);
    @(negedge wb_clk_i);
    check("ack_single_cycle", 16'(wbs_ack_o), 16'd0);
    cpu_wr(2'd2, 8'h80);
    peek(2'd1, v); check("unf_cleared", 16'(v), 16'h04);

    // C2H full: CPU push and host pop on the same edge
    for (int i = 0; i < 8; i++) cpu_wr(2'd0, 8'(8'hA0 + i));
    peek(2'd3, v); check("c2h_full_count", 16'(v), 16'h08);
    peek(2'd1, v); check("c2h_full_status", 16'(v), 16'h08);
    @(negedge wb_clk_i);
    sel = 1'b1; bus_cyc = 1'b1; bus_we = 1'b1; addr = 2'd0; data_in = 8'hAA;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 4'd0;
    @(negedge wb_clk_i);
    sel = 1'b0; bus_cyc = 1'b0; bus_we = 1'b0;
    check("full_pp_ack", 16'(wbs_ack_o), 16'd1);
    check("full_pp_data", 16'(wbs_dat_o), 16'hA0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    peek(2'd3, v); check("full_pp_count", 16'(v), 16'h08);
    peek(2'd1, v); check("full_pp_no_ovf", 16'(v), 16'h08);
    for (int i = 0; i < 7; i++) exp_c2h[i] = 8'(8'hA1 + i);
    exp_c2h[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      host_xfer(1'b0, 2'd0, 8'h00, v, lat);
      check($sformatf("c2h_drain_%0d", i), 16'(v), 16'(exp_c2h[i]));
    end
    peek(2'd1, v); check("c2h_drained_status", 16'(v), 16'h04);

    // Empty H2C: CPU pop and host push on the same edge
    @(negedge wb_clk_i);
    sel = 1'b1; bus_cyc = 1'b1; bus_we = 1'b0; addr = 2'd0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 4'd0; wbs_dat_i = 8'h42;
    #1 v = data_out;
    check("empty_pp_rd", 16'(v), 16'h00);
    @(negedge wb_clk_i);
    sel = 1'b0; bus_cyc = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    peek(2'd3, v); check("empty_pp_count", 16'(v), 16'h10);
    peek(2'd1, v); check("empty_pp_status", 16'(v), 16'h25);
    cpu_rd(2'd0, v); check("empty_pp_data", 16'(v), 16'h42);
    cpu_wr(2'd2, 8'h80);
    peek(2'd1, v); check("empty_pp_cleared", 16'(v), 16'h04);

    // Sticky clear and underflow on the same edge: underflow wins
    @(negedge wb_clk_i);
    sel = 1'b1; bus_cyc = 1'b1; bus_we = 1'b1; addr = 2'd2; data_in = 8'h80;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 4'd0;
    @(negedge wb_clk_i);
    sel = 1'b0; bus_cyc = 1'b0; bus_we = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    peek(2'd1, v); check("clr_vs_unf", 16'(v), 16'h24);
    cpu_wr(2'd2, 8'h80);
    peek(2'd1, v); check("clr_after", 16'(v), 16'h04);

    // Host STATUS / COUNT / reserved register
    host_xfer(1'b1, 2'd0, 8'h01, v, lat);
    host_xfer(1'b1, 2'd0, 8'h02, v, lat);
    host_xfer(1'b0, 2'd2, 8'h00, v, lat); check("host_count", 16'(v), 16'h20);
    host_xfer(1'b0, 2'd1, 8'h00, v, lat); check("host_status", 16'(v), 16'h05);
    host_xfer(1'b1, 2'd3, 8'hFF, v, lat);
    host_xfer(1'b0, 2'd3, 8'h00, v, lat); check("host_reg3", 16'(v), 16'h00);
    cpu_rd(2'd0, v); check("host_q0", 16'(v), 16'h01);
    cpu_rd(2'd0, v); check("host_q1", 16'(v), 16'h02);

    // Pointer wrap: 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      host_xfer(1'b1, 2'd0, 8'(8'h30 + i), v, lat);
      cpu_rd(2'd0, v);
      check($sformatf("wrap_%0d", i), 16'(v), 16'(8'h30 + i));
    end
    peek(2'd3, v); check("wrap_count", 16'(v), 16'h00);
    peek(2'd1, v); check("wrap_status", 16'(v), 16'h04);

    // Interrupts
    cpu_wr(2'd2, 8'h01);
    host_xfer(1'b1, 2'd0, 8'h5A, v, lat);
    check("irq_same_cycle", 16'(irq), 16'd0);
    @(negedge wb_clk_i);
`ifdef BUS_MAILBOX_IRQ_EN
    check("irq_rise", 16'(irq), 16'd1);
    peek(2'd2, v); check("ctrl_readback", 16'(v), 16'h01);
`else
    check("irq_tied", 16'(irq), 16'd0);
    peek(2'd2, v); check("ctrl_readback", 16'(v), 16'h00);
`endif
    cpu_rd(2'd0, v); check("irq_pop_data", 16'(v), 16'h5A);
    @(negedge wb_clk_i);
    check("irq_fall", 16'(irq), 16'd0);
    cpu_wr(2'd0, 8'h77);
    @(negedge wb_clk_i);
`ifdef BUS_MAILBOX_IRQ_EN
    check("host_irq_rise", 16'(host_irq), 16'd1);
`else
    check("host_irq_tied", 16'(host_irq), 16'd0);
`endif
    host_xfer(1'b0, 2'd0, 8'h00, v, lat); check("host_irq_pop", 16'(v), 16'h77);
    @(negedge wb_clk_i);
    check("host_irq_fall", 16'(host_irq), 16'd0);
    cpu_wr(2'd2, 8'h00);

    // Asynchronous reset while an ack is pending
    host_xfer(1'b1, 2'd0, 8'h31, v, lat);
    host_xfer(1'b1, 2'd0, 8'h32, v, lat);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 4'd0; wbs_dat_i = 8'h33;
    @(posedge wb_clk_i);
    #2;
    check("pre_rst_ack", 16'(wbs_ack_o), 16'd1);
    peek(2'd3, v); check("pre_rst_count", 16'(v), 16'h30);
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", 16'(wbs_ack_o), 16'd0);
    peek(2'd3, v); check("async_rst_count", 16'(v), 16'h00);
    peek(2'd1, v); check("async_rst_status", 16'(v), 16'h04);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("post_rst_no_ack", 16'(wbs_ack_o), 16'd0);
    peek(2'd3, v); check("post_rst_count", 16'(v), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
